// File: rtl/rt_ibex_pcs_frame_stack_pkg.sv
// rtl/rt_ibex_pcs_frame_stack_pkg.sv - PCS backend selection enum and frame stack sizing helpers
package rt_ibex_pcs_frame_stack_pkg;

  // Backends selectable by the PCS register file's generate block.
  typedef enum integer {
    NoPCS,
    LifoPCS,
    FrameStackPCS
  } pcs_e;

  function automatic int unsigned pcs_sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned pcs_idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rt_ibex_pcs_frame_stack.sv
// rtl/rt_ibex_pcs_frame_stack.sv - PCS frame stack with level tags, status and deferred pop
module rt_ibex_pcs_frame_stack
  import rt_ibex_pcs_frame_stack_pkg::*;
#(
  parameter int unsigned NrSavedRegs   = 18,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IrqLevelWidth = 8,
  parameter int unsigned Depth         = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [IrqLevelWidth-1:0]           irq_level_i,
  input  logic                               irq_ack_i,
  input  logic                               irq_exit_i,
  input  logic [NrSavedRegs*DataWidth-1:0]   store_data_i,
  input  logic                               next_mret_i,
  output logic [NrSavedRegs*DataWidth-1:0]   restore_data_o,
  output logic                               restore_en_o,
  output logic [pcs_sp_width(Depth)-1:0]     depth_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic                               overflow_o,
  output logic [IrqLevelWidth-1:0]           top_level_o
);

  localparam int unsigned FrameW = NrSavedRegs * DataWidth;
  localparam int unsigned SpW    = pcs_sp_width(Depth);
  localparam int unsigned IdxW   = pcs_idx_width(Depth);
  localparam logic [SpW-1:0] SpMax = SpW'(Depth);

  typedef enum logic {
    IDLE,
    POP_PEND
  } pcs_fs_state_e;

  pcs_fs_state_e state_q, state_d;

  logic [SpW-1:0]           sp_q, sp_d;
  logic [FrameW-1:0]        frames_rd [Depth];
  logic [IrqLevelWidth-1:0] tags_rd   [Depth];
  logic [IdxW-1:0]          wr_idx, top_idx;
  logic [FrameW-1:0]        top_frame;
  logic [FrameW-1:0]        restore_data_q;
  logic                     restore_en_q, overflow_q;
  logic                     full, empty, pend_q, pop_req;
  logic                     push_ok, pop_fire, discard_fire;

  assign full    = (sp_q == SpMax);
  assign empty   = (sp_q == '0);
  assign pend_q  = (state_q == POP_PEND);
  assign pop_req = next_mret_i | pend_q;

  // Push always wins the cycle; a colliding pop is deferred, a colliding discard is dropped.
  assign push_ok      = irq_ack_i & ~full;
  assign pop_fire     = ~irq_ack_i & pop_req & ~empty;
  assign discard_fire = ~irq_ack_i & ~pop_req & irq_exit_i & ~empty;

  assign wr_idx  = sp_q[IdxW-1:0];
  assign top_idx = sp_q[IdxW-1:0] - IdxW'(1);

  for (genvar g = 0; g < Depth; g++) begin : g_frame
    logic [FrameW-1:0]        frame_q;
    logic [IrqLevelWidth-1:0] tag_q;
    logic                     we;

    assign we = push_ok & (wr_idx == IdxW'(g));

    always_ff @(posedge clk_i) begin
      if (we) begin
        frame_q <= store_data_i;
        tag_q   <= irq_level_i;
      end
    end

    assign frames_rd[g] = frame_q;
    assign tags_rd[g]   = tag_q;
  end

  assign top_frame = frames_rd[top_idx];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (irq_ack_i && next_mret_i) state_d = POP_PEND;
      POP_PEND: if (!irq_ack_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    sp_d = sp_q;
    if (push_ok) begin
      sp_d = sp_q + SpW'(1);
    end else if ((pop_fire || discard_fire) && !empty) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      sp_q           <= '0;
      overflow_q     <= 1'b0;
      restore_en_q   <= 1'b0;
      restore_data_q <= '0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      restore_en_q <= pop_fire;
      if (irq_ack_i && full) overflow_q <= 1'b1;
      if (pop_fire) restore_data_q <= top_frame;
    end
  end

  assign restore_data_o = restore_data_q;
  assign restore_en_o   = restore_en_q;
  assign depth_o        = sp_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign overflow_o     = overflow_q;
  assign top_level_o    = empty ? '0 : tags_rd[top_idx];

  sp_in_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sp_q <= SpMax);

  pulse_needs_pops_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (restore_en_q && $past(restore_en_q)) |-> ($past(pop_fire) && $past(pop_fire, 2)));

endmodule

// File: tb/tb_rt_ibex_pcs_frame_stack.sv
// tb/tb_rt_ibex_pcs_frame_stack.sv - randomized and directed bench with a queue-based reference model
module tb_rt_ibex_pcs_frame_stack;

  localparam int NR    = 18;
  localparam int DW    = 32;
  localparam int LW    = 8;
  localparam int DEPTH = 4;
  localparam int FW    = NR * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] irq_level = '0;
  logic          irq_ack = 1'b0;
  logic          irq_exit = 1'b0;
  logic [FW-1:0] store_data = '0;
  logic          next_mret = 1'b0;
  logic [FW-1:0] restore_data;
  logic          restore_en;
  logic [2:0]    depth;
  logic          full, empty, overflow;
  logic [LW-1:0] top_level;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] mq_frame [$];
  logic [LW-1:0] mq_lvl   [$];
  bit            m_pend, m_ovf, m_ren;
  logic [FW-1:0] m_rdata;

  rt_ibex_pcs_frame_stack #(
    .NrSavedRegs  (NR),
    .DataWidth    (DW),
    .IrqLevelWidth(LW),
    .Depth        (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .irq_level_i   (irq_level),
    .irq_ack_i     (irq_ack),
    .irq_exit_i    (irq_exit),
    .store_data_i  (store_data),
    .next_mret_i   (next_mret),
    .restore_data_o(restore_data),
    .restore_en_o  (restore_en),
    .depth_o       (depth),
    .full_o        (full),
    .empty_o       (empty),
    .overflow_o    (overflow),
    .top_level_o   (top_level)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int w = 0; w < NR; w++) f[w*DW +: DW] = $urandom;
    return f;
  endfunction

  task automatic model_reset();
    mq_frame.delete();
    mq_lvl.delete();
    m_pend  = 1'b0;
    m_ovf   = 1'b0;
    m_ren   = 1'b0;
    m_rdata = '0;
  endtask

  // Push beats pop beats discard; a pop blocked by a push waits one more cycle.
  task automatic model_step();
    bit pop_req;
    pop_req = next_mret || m_pend;
    m_ren = 1'b0;
    if (irq_ack) begin
      if (mq_frame.size() < DEPTH) begin
        mq_frame.push_back(store_data);
        mq_lvl.push_back(irq_level);
      end else begin
        m_ovf = 1'b1;
      end
      m_pend = pop_req;
    end else if (pop_req) begin
      m_pend = 1'b0;
      if (mq_frame.size() > 0) begin
        m_rdata = mq_frame.pop_back();
        void'(mq_lvl.pop_back());
        m_ren = 1'b1;
      end
    end else if (irq_exit && mq_frame.size() > 0) begin
      void'(mq_frame.pop_back());
      void'(mq_lvl.pop_back());
    end
  endtask

  task automatic cyc(input bit ack, input bit mret, input bit ex,
                     input logic [LW-1:0] lvl, input logic [FW-1:0] d);
    irq_ack    = ack;
    next_mret  = mret;
    irq_exit   = ex;
    irq_level  = lvl;
    store_data = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL reset_restore_en got=%0b exp=0", restore_en); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (top_level !== 8'd0) begin errors++; $display("FAIL reset_top_level got=%0d exp=0", top_level); end
    checks++; if (restore_data !== '0) begin errors++; $display("FAIL reset_restore_data got=%h exp=0", restore_data); end
  endtask

  task automatic test_push_pop();
    logic [FW-1:0] a;
    a = rand_frame();
    a[31:0]  = 32'h8000_0100;
    a[63:32] = 32'h8000_000B;
    cyc(1'b1, 1'b0, 1'b0, 8'd3, a);
    checks++; if (depth !== 3'd1) begin errors++; $display("FAIL pp_depth got=%0d exp=1", depth); end
    checks++; if (top_level !== 8'd3) begin errors++; $display("FAIL pp_top_level got=%0d exp=3", top_level); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pp_empty got=%0b exp=0", empty); end
    idle();
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL pp_early_pulse got=%0b exp=0", restore_en); end
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    checks++; if (restore_en !== 1'b1) begin errors++; $display("FAIL pp_pulse got=%0b exp=1", restore_en); end
    checks++; if (restore_data !== a) begin errors++; $display("FAIL pp_data got=%h exp=%h", restore_data, a); end
    checks++; if (top_level !== 8'd0) begin errors++; $display("FAIL pp_top_after got=%0d exp=0", top_level); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL pp_depth_after got=%0d exp=0", depth); end
    idle();
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL pp_single_pulse got=%0b exp=0", restore_en); end
    checks++; if (restore_data !== a) begin errors++; $display("FAIL pp_data_hold got=%h exp=%h", restore_data, a); end
  endtask

  task automatic test_lifo_full();
    logic [FW-1:0] f [5];
    for (int i = 0; i < 5; i++) f[i] = rand_frame();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, LW'(i + 1), f[i]);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL lifo_full got=%0b exp=1", full); end
    checks++; if (depth !== 3'd4) begin errors++; $display("FAIL lifo_depth got=%0d exp=4", depth); end
    checks++; if (top_level !== 8'd4) begin errors++; $display("FAIL lifo_top got=%0d exp=4", top_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL lifo_no_ovf got=%0b exp=0", overflow); end
    cyc(1'b1, 1'b0, 1'b0, 8'd5, f[4]);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL lifo_overflow got=%0b exp=1", overflow); end
    checks++; if (depth !== 3'd4) begin errors++; $display("FAIL lifo_depth_ovf got=%0d exp=4", depth); end
    checks++; if (top_level !== 8'd4) begin errors++; $display("FAIL lifo_top_ovf got=%0d exp=4", top_level); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0, '0);
      checks++; if (restore_en !== 1'b1) begin errors++; $display("FAIL lifo_pulse%0d got=%0b exp=1", i, restore_en); end
      checks++; if (restore_data !== f[3-i]) begin errors++; $display("FAIL lifo_data%0d got=%h exp=%h", i, restore_data, f[3-i]); end
      checks++; if (top_level !== LW'(3 - i)) begin errors++; $display("FAIL lifo_top%0d got=%0d exp=%0d", i, top_level, 3 - i); end
    end
    idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lifo_empty got=%0b exp=1", empty); end
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL lifo_pulse_end got=%0b exp=0", restore_en); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL lifo_ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_collision();
    logic [FW-1:0] a, b;
    a = rand_frame();
    b = rand_frame();
    cyc(1'b1, 1'b0, 1'b0, 8'd7, a);
    cyc(1'b1, 1'b1, 1'b0, 8'd9, b);
    checks++; if (depth !== 3'd2) begin errors++; $display("FAIL col_depth got=%0d exp=2", depth); end
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL col_no_pulse got=%0b exp=0", restore_en); end
    checks++; if (top_level !== 8'd9) begin errors++; $display("FAIL col_top got=%0d exp=9", top_level); end
    idle();
    checks++; if (restore_en !== 1'b1) begin errors++; $display("FAIL col_pulse got=%0b exp=1", restore_en); end
    checks++; if (restore_data !== b) begin errors++; $display("FAIL col_data got=%h exp=%h", restore_data, b); end
    checks++; if (depth !== 3'd1) begin errors++; $display("FAIL col_depth_after got=%0d exp=1", depth); end
    idle();
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL col_one_pulse got=%0b exp=0", restore_en); end
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    checks++; if (restore_data !== a) begin errors++; $display("FAIL col_drain got=%h exp=%h", restore_data, a); end
    idle();
  endtask

  task automatic test_empty_discard();
    logic [FW-1:0] a, b;
    a = rand_frame();
    b = rand_frame();
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL emp_pop_pulse got=%0b exp=0", restore_en); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL emp_pop_depth got=%0d exp=0", depth); end
    cyc(1'b1, 1'b0, 1'b0, 8'd1, a);
    cyc(1'b1, 1'b0, 1'b0, 8'd2, b);
    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    checks++; if (depth !== 3'd1) begin errors++; $display("FAIL disc_depth got=%0d exp=1", depth); end
    checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL disc_pulse got=%0b exp=0", restore_en); end
    checks++; if (top_level !== 8'd1) begin errors++; $display("FAIL disc_top got=%0d exp=1", top_level); end
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    checks++; if (restore_data !== a) begin errors++; $display("FAIL disc_pop_data got=%h exp=%h", restore_data, a); end
    idle();
  endtask

  task automatic test_reset_pending();
    cyc(1'b1, 1'b0, 1'b0, 8'd4, rand_frame());
    cyc(1'b1, 1'b1, 1'b0, 8'd6, rand_frame());
    idle_inputs_only();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL rstp_async_depth got=%0d exp=0", depth); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstp_async_ovf got=%0b exp=0", overflow); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstp_async_empty got=%0b exp=1", empty); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL rstp_pulse%0d got=%0b exp=0", i, restore_en); end
      checks++; if (depth !== 3'd0) begin errors++; $display("FAIL rstp_depth%0d got=%0d exp=0", i, depth); end
    end
  endtask

  task automatic idle_inputs_only();
    irq_ack   = 1'b0;
    next_mret = 1'b0;
    irq_exit  = 1'b0;
  endtask

  task automatic test_random();
    int unsigned exp_n;
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 20,
          LW'($urandom), rand_frame());
      exp_n = mq_frame.size();
      checks++; if (restore_en !== m_ren) begin errors++; $display("FAIL rnd_en c=%0d got=%0b exp=%0b", c, restore_en, m_ren); end
      checks++; if (restore_data !== m_rdata) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, restore_data, m_rdata); end
      checks++; if (depth !== 3'(exp_n)) begin errors++; $display("FAIL rnd_depth c=%0d got=%0d exp=%0d", c, depth, exp_n); end
      checks++; if (full !== (exp_n == DEPTH)) begin errors++; $display("FAIL rnd_full c=%0d got=%0b", c, full); end
      checks++; if (empty !== (exp_n == 0)) begin errors++; $display("FAIL rnd_empty c=%0d got=%0b", c, empty); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
      checks++; if (top_level !== ((exp_n == 0) ? 8'd0 : mq_lvl[exp_n-1])) begin
        errors++; $display("FAIL rnd_top c=%0d got=%0d", c, top_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_lifo_full();
    test_collision();
    test_empty_discard();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
